// File: rtl/to8bit_if.sv
// Word-side and byte-side signals of the word-to-byte serializer.
// The master modport drives words in; the slave modport is the serializer.
interface to8bit_if;
  logic        enb;
  logic [1:0]  dataS;
  logic [7:0]  dataIn8;
  logic [15:0] dataIn16;
  logic [31:0] dataIn32;
  logic        validIn;
  logic        readyIn;
  logic [7:0]  dataOut;
  logic        validOut;
  logic [1:0]  dataSInternal;
  logic [1:0]  contador;
  logic        busy;

  modport master (
    output enb, dataS, dataIn8, dataIn16, dataIn32, validIn,
    input  readyIn, dataOut, validOut, dataSInternal, contador, busy
  );

  modport slave (
    input  enb, dataS, dataIn8, dataIn16, dataIn32, validIn,
    output readyIn, dataOut, validOut, dataSInternal, contador, busy
  );
endinterface

// File: rtl/to8bit.sv
// Word-to-byte serializer: takes an 8/16/32-bit word per handshake and emits
// it MSB byte first, one byte per enabled clock, with no bubble between words.
module to8bit (
  input  logic     clk,
  input  logic     rst,
  to8bit_if.slave  bus
);

  logic [23:0] pend_q, pend_d;
  logic [1:0]  rem_q, rem_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        valid_out_q, valid_out_d;
  logic [1:0]  data_s_q, data_s_d;
  logic [1:0]  contador_q, contador_d;
  logic        busy_q, busy_d;
  logic        ready;
  logic        accept;

  // Ready also while the last byte is on the output, so words stream back-to-back.
  assign ready  = bus.enb && (rem_q == 2'd0);
  assign accept = ready && bus.validIn;

  always_comb begin
    pend_d      = pend_q;
    rem_d       = rem_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    data_s_d    = data_s_q;
    contador_d  = contador_q;
    if (bus.enb) begin
      if (accept) begin
        data_s_d    = bus.dataS;
        contador_d  = 2'd0;
        valid_out_d = 1'b1;
        case (bus.dataS)
          2'b01: begin
            data_out_d = bus.dataIn16[15:8];
            pend_d     = {bus.dataIn16[7:0], 16'h0000};
            rem_d      = 2'd1;
          end
          2'b10: begin
            data_out_d = bus.dataIn32[31:24];
            pend_d     = bus.dataIn32[23:0];
            rem_d      = 2'd3;
          end
          default: begin
            data_out_d = bus.dataIn8;
            pend_d     = 24'h000000;
            rem_d      = 2'd0;
          end
        endcase
      end else if (rem_q != 2'd0) begin
        data_out_d  = pend_q[23:16];
        pend_d      = {pend_q[15:0], 8'h00};
        rem_d       = rem_q - 2'd1;
        contador_d  = contador_q + 2'd1;
        valid_out_d = 1'b1;
      end else begin
        valid_out_d = 1'b0;
      end
    end
    busy_d = (rem_d != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= 24'h000000;
      rem_q       <= 2'd0;
      data_out_q  <= 8'h00;
      valid_out_q <= 1'b0;
      data_s_q    <= 2'd0;
      contador_q  <= 2'd0;
      busy_q      <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      rem_q       <= rem_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      data_s_q    <= data_s_d;
      contador_q  <= contador_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.readyIn       = ready;
  assign bus.dataOut       = data_out_q;
  assign bus.validOut      = valid_out_q;
  assign bus.dataSInternal = data_s_q;
  assign bus.contador      = contador_q;
  assign bus.busy          = busy_q;

endmodule

// File: doc/to8bit.md
# to8bit

Word-to-byte serializer: accepts one 8-, 16- or 32-bit word per handshake and emits it as a stream of 8-bit bytes, most significant byte first, one byte per enabled clock. It is the transmit-side counterpart of the byte-to-word converter. Width selection uses the same `dataS` encoding, so a byte stream produced here reassembles into the original words on the receive side. It sits between the word-level datapath and the 8-bit serial link.

## Interface
Parameters: none.

Ports:
- `clk` input 1: single clock, all state on posedge.
- `rst` input 1: asynchronous, active-high reset.
- `enb` input 1: clock enable. When low, all state is frozen.
- `dataS` input 2: width select for the next word accepted.
  - `00`/`11` = 8 bits.
  - `01` = 16 bits.
  - `10` = 32 bits.
- `dataIn8` input 8: word source when width is 8.
- `dataIn16` input 16: word source when width is 16.
- `dataIn32` input 32: word source when width is 32.
- `validIn` input 1: upstream offers a word.
- `readyIn` output 1: combinational; word is accepted at a posedge when `validIn && readyIn`.
- `dataOut` output 8: registered serial byte.
- `validOut` output 1: registered; `dataOut` holds a valid byte.
- `dataSInternal` output 2: latched width code of the word in flight.
- `contador` output 2: byte index of the byte currently on `dataOut` (0 = MSB byte).
- `busy` output 1: registered; high while bytes of the current word remain after the one on `dataOut`.

## Operation
- Internal state:
  - 24-bit shift register `pend` holding the remaining bytes.
  - 2-bit `rem` counting the bytes still to emit after the current one.
- `readyIn = enb && (rem == 0)`. This is true when idle and also while the last byte of a word is on `dataOut`, so back-to-back words stream without bubbles.
- On accept, at the posedge:
  - `dataSInternal <= dataS`, `contador <= 0`, `validOut <= 1`.
  - Width 8: `dataOut <= dataIn8`; `rem <= 0`.
  - Width 16: `dataOut <= dataIn16[15:8]`; `pend[23:16] <= dataIn16[7:0]`; `rem <= 1`.
  - Width 32: `dataOut <= dataIn32[31:24]`; `pend <= dataIn32[23:0]`; `rem <= 3`.
- Enabled posedge with `rem != 0`:
  - `dataOut <= pend[23:16]`.
  - `pend <= pend << 8`.
  - `rem <= rem - 1`.
  - `contador <= contador + 1`.
  - `validOut` stays 1.
- Enabled posedge with `rem == 0` and no accept:
  - `validOut <= 0`.
  - `dataOut`, `contador` and `dataSInternal` hold their last values.
- `busy` equals `rem != 0`, registered together with `rem`.
- `dataS` is sampled only on accept. Changes mid-word do not affect the word in flight.
- Unused bits of `pend` shift in zeros.

## Timing
- Latency: the first byte appears on `dataOut` on the same posedge that accepts the word (1 cycle from `validIn`/`readyIn` asserted).
- Throughput: 1 byte per enabled cycle. A 32-bit word occupies 4 cycles, a 16-bit word 2 cycles, an 8-bit word 1 cycle.
- Downstream samples `dataOut` on every enabled posedge where `validOut = 1`. There is no backpressure from downstream.
- `enb` low:
  - `readyIn = 0`.
  - All registers hold, including `validOut` and `dataOut`.
  - Streaming resumes on the next enabled edge with no byte lost or duplicated.
- Reset (asynchronous, any time, including mid-word). Immediately:
  - `dataOut = 0`, `validOut = 0`, `busy = 0`.
  - `contador = 0`, `dataSInternal = 0`.
  - `rem = 0`, `pend = 0`.
  - Remaining bytes are discarded.
  - `readyIn` follows `enb` once `rst` deasserts. The first accept can occur on the first posedge after deassertion.
- Simultaneous last-byte emission and new accept: the new word's MSB byte replaces the last byte on the next edge. `contador` returns to 0.

## Test plan
- 8-bit streaming:
  - Stimulus: `dataS=00`, `validIn=1`, `dataIn8 = A5`, then `3C`.
  - Response: `dataOut` = A5, 3C on consecutive cycles; `validOut = 1`; `readyIn` stays 1; `contador` stays 0.
- 16-bit word:
  - Stimulus: `dataS=01`, `dataIn16 = BEEF`, single `validIn` pulse.
  - Response:
    - Bytes BE then EF; `contador` 0, 1.
    - `readyIn = 0` during the BE cycle; `busy = 1` during the BE cycle, 0 during the EF cycle.
    - `validOut` drops the cycle after EF.
- 32-bit back-to-back:
  - Stimulus: `01020304` then `A0B0C0D0`, `validIn` held high.
  - Response: bytes 01 02 03 04 A0 B0 C0 D0 with no gap; `readyIn` high only while 04 and D0 are on `dataOut`.
- Width change mid-word:
  - Stimulus: accept 32-bit `11223344`, switch `dataS` to 01 after the first byte, present `dataIn16 = 5566`.
  - Response: 11 22 33 44 complete, then 55 66; `dataSInternal` = 10, then 01.
- Enable stall:
  - Stimulus: `enb` low for 2 cycles after byte 22 of `11223344`.
  - Response: `dataOut = 22` holds; `readyIn = 0`; then 33, 44 follow.
- Asynchronous reset mid-word:
  - Stimulus: assert `rst` between edges while byte 22 is out.
  - Response: all outputs 0 immediately; after release, no residual 33/44 appear and the next accepted word starts at `contador = 0`.
